// File: rtl/pipe_pkg.sv
// Shared definitions for the datapath pipeline stage registers.
package pipe_pkg;

    // Stage occupancy encoded as {main_valid, skid_valid}; 2'b01 is unused.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b10,
        ST_FULL  = 2'b11
    } stage_state_t;

    // Datapath bubble encoding, used as the default reset/flush payload.
    localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/pipe_stage_hs_flopenrc.sv
// Register with enable, synchronous reset and synchronous clear.
// Both reset and clear load RESET_VAL; reset wins over clear, clear over enable.
module flopenrc #(
    parameter int unsigned       WIDTH     = 32,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Payload register update.
    always_ff @(posedge clk) begin
        if (rst)
            q <= RESET_VAL;
        else if (clr)
            q <= RESET_VAL;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline stage with a 2-entry skid buffer and synchronous flush.
// in_ready comes straight from the state register, so no combinational path
// runs from the downstream ready to the upstream ready.
module pipe_stage_hs
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_VAL  = WIDTH'(NOP),
    parameter bit               FLUSH_DATA = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    stage_state_t     state_q, state_d;
    logic             main_valid, skid_valid;
    logic             in_fire, out_fire;
    logic             main_en, skid_en, main_from_skid, data_clr;
    logic [WIDTH-1:0] main_d, main_q, skid_q;

    assign main_valid = state_q[1];
    assign skid_valid = state_q[0];
    assign in_ready   = !skid_valid;
    assign out_valid  = main_valid;
    assign out_data   = main_q;
    assign in_fire    = in_valid & in_ready;
    assign out_fire   = out_valid & out_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_EMPTY;
        else
            state_q <= state_d;
    end

    // Next occupancy from the handshakes; flush always empties the stage.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: if (in_fire) state_d = ST_BUSY;
                ST_BUSY: begin
                    if (in_fire && !out_fire)
                        state_d = ST_FULL;
                    else if (!in_fire && out_fire)
                        state_d = ST_EMPTY;
                end
                ST_FULL:  if (out_fire) state_d = ST_BUSY;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    // Register load controls; flush suppresses every load so in_fire is dropped.
    always_comb begin
        main_en        = 1'b0;
        skid_en        = 1'b0;
        main_from_skid = 1'b0;
        data_clr       = flush & FLUSH_DATA;
        if (!flush) begin
            unique case (state_q)
                ST_EMPTY: main_en = in_fire;
                ST_BUSY: begin
                    main_en = in_fire & out_fire;
                    skid_en = in_fire & !out_fire;
                end
                ST_FULL: begin
                    main_en        = out_fire;
                    main_from_skid = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign main_d = main_from_skid ? skid_q : in_data;

    flopenrc #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
        .clk (clk),
        .rst (rst),
        .clr (data_clr),
        .en  (main_en),
        .d   (main_d),
        .q   (main_q)
    );

    flopenrc #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
        .clk (clk),
        .rst (rst),
        .clr (data_clr),
        .en  (skid_en),
        .d   (in_data),
        .q   (skid_q)
    );

    // Simulation-time protocol properties.
    a_no_state_01: assert property (@(posedge clk) {main_valid, skid_valid} != 2'b01);

    a_out_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data)));

    a_ready_skid: assert property (@(posedge clk) in_ready == !skid_valid);

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Self-checking bench for pipe_stage_hs: directed steps followed by a random
// handshake run, checked against a queue-based occupancy model.
module tb_pipe_stage_hs;

    localparam logic [31:0] RV1 = 32'h0000_0000;
    localparam logic [31:0] RV0 = 32'h0BAD_F00D;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_data;
    logic        in_ready1, out_valid1, in_ready0, out_valid0;
    logic [31:0] out_data1, out_data0;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [31:0] mq[$];
    logic [31:0] sh1, sh0;
    int unsigned nin = 0, nout = 0;

    always #5 clk = ~clk;

    pipe_stage_hs #(.WIDTH(32), .RESET_VAL(RV1), .FLUSH_DATA(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .in_data   (in_data),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .out_data  (out_data1)
    );

    pipe_stage_hs #(.WIDTH(32), .RESET_VAL(RV0), .FLUSH_DATA(1'b0)) dut_nf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready0),
        .in_data   (in_data),
        .out_valid (out_valid0),
        .out_ready (out_ready),
        .out_data  (out_data0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: advance the model from the inputs present at the edge, then compare.
    task automatic step();
        bit inf, outf;
        @(posedge clk);
        inf  = in_valid && (mq.size() < 2);
        outf = (mq.size() > 0) && out_ready;
        if (rst) begin
            mq.delete();
            sh1 = RV1;
            sh0 = RV0;
        end else if (flush) begin
            if (outf) nout++;
            mq.delete();
            sh1 = RV1;
        end else begin
            if (outf) begin
                void'(mq.pop_front());
                nout++;
            end
            if (inf) begin
                mq.push_back(in_data);
                nin++;
            end
            if (mq.size() > 0) begin
                sh1 = mq[0];
                sh0 = mq[0];
            end
        end
        #1;
        chk("out_valid",    32'(out_valid1), 32'(mq.size() > 0));
        chk("in_ready",     32'(in_ready1),  32'(mq.size() < 2));
        chk("out_data",     out_data1,       sh1);
        chk("nf_out_valid", 32'(out_valid0), 32'(mq.size() > 0));
        chk("nf_in_ready",  32'(in_ready0),  32'(mq.size() < 2));
        chk("nf_out_data",  out_data0,       sh0);
    endtask

    initial begin
        sh1 = RV1;
        sh0 = RV0;
        flush     = 1'b0;
        out_ready = 1'b0;

        // Reset with a live upstream beat that must be ignored.
        rst = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
        step();
        step();
        chk("rst_out_valid", 32'(out_valid1), 32'd0);
        chk("rst_out_data",  out_data1,       32'd0);
        chk("rst_in_ready",  32'(in_ready1),  32'd1);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("post_rst_empty", 32'(out_valid1), 32'd0);

        // Streaming at full rate.
        for (int v = 1; v <= 4; v++) begin
            in_valid = 1'b1; in_data = 32'(v);
            step();
            chk("stream_data",  out_data1,      32'(v));
            chk("stream_ready", 32'(in_ready1), 32'd1);
        end
        in_valid = 1'b0;
        step();
        chk("stream_drain", 32'(out_valid1), 32'd0);

        // Backpressure fills the skid buffer, then drains in order.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA5;
        step();
        in_data = 32'hA6;
        step();
        chk("bp_full_ready", 32'(in_ready1), 32'd0);
        chk("bp_head",       out_data1,      32'hA5);
        in_valid = 1'b0;
        step();
        chk("bp_hold", out_data1, 32'hA5);
        out_ready = 1'b1;
        step();
        chk("bp_second",    out_data1,      32'hA6);
        chk("bp_ready_ret", 32'(in_ready1), 32'd1);
        step();
        chk("bp_empty", 32'(out_valid1), 32'd0);

        // Flush while FULL with a beat offered at the same edge.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11;
        step();
        in_data = 32'h22;
        step();
        flush = 1'b1; in_data = 32'd77;
        step();
        chk("fl_valid",    32'(out_valid1), 32'd0);
        chk("fl_data",     out_data1,       32'd0);
        chk("fl_ready",    32'(in_ready1),  32'd1);
        chk("fl_nf_held",  out_data0,       32'h11);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        step();
        chk("fl_no_77", 32'(out_valid1), 32'd0);

        // Flush in BUSY: the same-edge in_fire is discarded; FLUSH_DATA=0 keeps data.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1234;
        step();
        flush = 1'b1; in_data = 32'h55;
        step();
        chk("nf_hold_data",  out_data0,       32'h1234);
        chk("nf_hold_valid", 32'(out_valid0), 32'd0);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("nf_no_55", 32'(out_valid0), 32'd0);

        // Random handshakes with occasional flush and one reset pulse.
        for (int i = 0; i < 10000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            rst       = (i == 5000);
            step();
            if (i == 5000)
                chk("mid_rst_empty", 32'(out_valid1), 32'd0);
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("final_empty", 32'(out_valid1), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
